corr_scan_ctrl: RTL and testbench

Row-scan sequencer for the 21-disparity stereo correlator array. It accepts left/right pixel pairs from the rectification stage over a valid/ready handshake and drives the array's shared `wen` enable and pixel inputs. It paces the free-running multiply/accumulate pipeline so every captured correlation is settled. It tags each settled result set with its column index and drains the array at end of row.

---
 rtl/corr_scan_if.sv | 35 +++
 rtl/corr_scan_ctrl.sv | 157 +++++++++++++++
 tb/tb_corr_scan_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/corr_scan_if.sv
// Handshake and array-drive bundle between the rectification stage, the
// correlator array and corr_scan_ctrl.
interface corr_scan_if #(
  parameter int COL_W = 10
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_l_1;
  logic [7:0]       in_l_2;
  logic [7:0]       in_r_1;
  logic [7:0]       in_r_2;
  logic [7:0]       d_l_1;
  logic [7:0]       d_l_2;
  logic [7:0]       d_r_1;
  logic [7:0]       d_r_2;
  logic             wen;
  logic             res_valid;
  logic [COL_W-1:0] res_col;
  logic             row_done;
  logic             busy;
  logic [15:0]      stall_cnt;

  modport master (
    output start, in_valid, in_l_1, in_l_2, in_r_1, in_r_2,
    input  in_ready, d_l_1, d_l_2, d_r_1, d_r_2, wen, res_valid, res_col,
           row_done, busy, stall_cnt
  );

  modport slave (
    input  start, in_valid, in_l_1, in_l_2, in_r_1, in_r_2,
    output in_ready, d_l_1, d_l_2, d_r_1, d_r_2, wen, res_valid, res_col,
           row_done, busy, stall_cnt
  );
endinterface

// File: rtl/corr_scan_ctrl.sv
// Row-scan sequencer for the stereo correlator array: paces pixel slots,
// drains the shift chain and tags settled results. Optional CORR_SCAN_STALL_CNT_EN.
module corr_scan_ctrl #(
  parameter int ROW_W = 640,
  parameter int DISP  = 21,
  parameter int SLOT  = 4,
  parameter int COL_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  corr_scan_if.slave  bus
);
  // Slot counter must reach ROW_W+2 (pixels plus two drain slots).
  localparam int CW = COL_W + 1;

  typedef enum logic [1:0] {IDLE, ACCEPT, SETTLE, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [3:0]       slot_q, slot_d;
  logic [CW-1:0]    wcnt_q, wcnt_d;
  logic [7:0]       d_l_1_q, d_l_1_d, d_l_2_q, d_l_2_d;
  logic [7:0]       d_r_1_q, d_r_1_d, d_r_2_q, d_r_2_d;
  logic             wen_q, wen_d;
  logic             in_ready_q, in_ready_d;
  logic             res_valid_q, res_valid_d;
  logic [COL_W-1:0] res_col_q, res_col_d;
  logic             row_done_q, row_done_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    wcnt_d   = wcnt_q;
    d_l_1_d  = d_l_1_q;
    d_l_2_d  = d_l_2_q;
    d_r_1_d  = d_r_1_q;
    d_r_2_d  = d_r_2_q;
    wen_d    = 1'b0;
    // wcnt_q counts the current wen, so slot s carries wcnt_q = s+1 and tags column s-2.
    res_valid_d = wen_q && (wcnt_q >= CW'(DISP + 2));
    res_col_d   = res_valid_d ? COL_W'(wcnt_q - CW'(3)) : res_col_q;
    row_done_d  = wen_q && (wcnt_q == CW'(ROW_W + 2));

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ACCEPT;
          wcnt_d  = '0;
        end
      end
      ACCEPT: begin
        if (bus.in_valid) begin
          d_l_1_d = bus.in_l_1;
          d_l_2_d = bus.in_l_2;
          d_r_1_d = bus.in_r_1;
          d_r_2_d = bus.in_r_2;
          wen_d   = 1'b1;
          wcnt_d  = wcnt_q + CW'(1);
          slot_d  = 4'(SLOT - 2);
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        // The last drain slot is cut short: the row ends once its result is tagged.
        if (row_done_q) begin
          state_d = IDLE;
        end else if (slot_q == 4'd0) begin
          state_d = (wcnt_q < CW'(ROW_W)) ? ACCEPT : FLUSH;
        end else begin
          slot_d = slot_q - 4'd1;
        end
      end
      FLUSH: begin
        d_l_1_d = 8'd0;
        d_l_2_d = 8'd0;
        d_r_1_d = 8'd0;
        d_r_2_d = 8'd0;
        wen_d   = 1'b1;
        wcnt_d  = wcnt_q + CW'(1);
        slot_d  = 4'(SLOT - 2);
        state_d = SETTLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == ACCEPT);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      wcnt_q      <= '0;
      d_l_1_q     <= '0;
      d_l_2_q     <= '0;
      d_r_1_q     <= '0;
      d_r_2_q     <= '0;
      wen_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_col_q   <= '0;
      row_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      wcnt_q      <= wcnt_d;
      d_l_1_q     <= d_l_1_d;
      d_l_2_q     <= d_l_2_d;
      d_r_1_q     <= d_r_1_d;
      d_r_2_q     <= d_r_2_d;
      wen_q       <= wen_d;
      in_ready_q  <= in_ready_d;
      res_valid_q <= res_valid_d;
      res_col_q   <= res_col_d;
      row_done_q  <= row_done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.d_l_1     = d_l_1_q;
  assign bus.d_l_2     = d_l_2_q;
  assign bus.d_r_1     = d_r_1_q;
  assign bus.d_r_2     = d_r_2_q;
  assign bus.wen       = wen_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_col   = res_col_q;
  assign bus.row_done  = row_done_q;
  assign bus.busy      = busy_q;

`ifdef CORR_SCAN_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && bus.start) begin
      stall_d = '0;
    end else if (state_q == ACCEPT && !bus.in_valid && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_corr_scan_ctrl.sv
// Self-checking bench for corr_scan_ctrl: randomized rows compared against a
// slot-timing model built from the recorded input history.
`timescale 1ns/1ps
module tb_corr_scan_ctrl;
  localparam int ROW_W   = 32;
  localparam int DISP    = 21;
  localparam int SLOT    = 4;
  localparam int COL_W   = 10;
  localparam int S_ROW_W = 5;
  localparam int S_SLOT  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  corr_scan_if #(.COL_W(COL_W)) bus ();
  corr_scan_if #(.COL_W(COL_W)) sbus ();

  corr_scan_ctrl #(.ROW_W(ROW_W), .DISP(DISP), .SLOT(SLOT), .COL_W(COL_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  corr_scan_ctrl #(.ROW_W(S_ROW_W), .DISP(DISP), .SLOT(S_SLOT), .COL_W(COL_W)) dut_short (
    .clk(clk), .rst(rst), .bus(sbus)
  );

  // Monitor history for the main instance
  bit          mon_en = 1'b0;
  bit          vhist [0:65535];
  logic [31:0] dhist [0:65535];
  int          acc_q[$];
  int          wen_q[$];
  logic [31:0] wd_q[$];
  int          res_cyc_q[$];
  int          res_col_q[$];
  int          done_q[$];
  int          busy_cnt;
  int          ready_cnt;

  always @(negedge clk) begin
    if (mon_en) begin
      vhist[cyc[15:0]] = bus.in_valid;
      dhist[cyc[15:0]] = {bus.in_l_1, bus.in_l_2, bus.in_r_1, bus.in_r_2};
      if (bus.in_valid && bus.in_ready) acc_q.push_back(cyc);
      if (bus.in_ready) ready_cnt++;
      if (bus.wen) begin
        wen_q.push_back(cyc);
        wd_q.push_back({bus.d_l_1, bus.d_l_2, bus.d_r_1, bus.d_r_2});
      end
      if (bus.res_valid) begin
        res_cyc_q.push_back(cyc);
        res_col_q.push_back(int'(bus.res_col));
      end
      if (bus.row_done) done_q.push_back(cyc);
      if (bus.busy) busy_cnt++;
    end
  end

  task automatic drive(input int starve_pct);
    bus.in_valid = ($urandom_range(99) >= starve_pct);
    {bus.in_l_1, bus.in_l_2, bus.in_r_1, bus.in_r_2} = $urandom;
  endtask

  // Runs one row on the main instance; abort_wen > 0 asserts rst during the
  // settle phase that follows that wen pulse.
  task automatic run_row(input int starve_pct, input bit mid_start, input int gap_at,
                         input int abort_wen, output int sc);
    int gap_left;
    bit aborted;
    gap_left = 7;
    aborted  = 1'b0;
    acc_q.delete(); wen_q.delete(); wd_q.delete();
    res_cyc_q.delete(); res_col_q.delete(); done_q.delete();
    busy_cnt = 0; ready_cnt = 0;
    @(posedge clk); #1;
    bus.start = 1'b1;
    drive(starve_pct);
    sc = cyc;
    mon_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      if (done_q.size() != 0) break;
      if (abort_wen > 0 && wen_q.size() == abort_wen && bus.wen) begin
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.wen !== 1'b0 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL async_reset: wen=%b busy=%b res_valid=%b in_ready=%b, required all 0",
                   bus.wen, bus.busy, bus.res_valid, bus.in_ready);
        end
        @(negedge clk); #1;
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
      @(posedge clk); #1;
      bus.start = mid_start && (i == 60);
      drive(starve_pct);
      if (gap_at >= 0 && gap_left > 0 && acc_q.size() == gap_at && bus.in_ready) begin
        bus.in_valid = 1'b0;
        gap_left--;
      end
    end
    mon_en = 1'b0;
    if (!aborted) begin
      vectors++;
      if (done_q.size() == 0) begin
        errors++;
        $display("FAIL row_timeout: row_done not seen, required within 3000 cycles");
      end
    end
  endtask

  // Reference: each pixel is taken on the first valid cycle at or after its
  // earliest slot; two zero drain slots follow; column p is tagged one cycle
  // after the wen of slot p+2, for p >= DISP-1.
  task automatic check_row(input int sc, input string tag);
    int exp_acc[$];
    int exp_wen[$];
    logic [31:0] exp_d[$];
    int earliest, c, stalls, nres, exp_stall;
    earliest = sc + 1;
    stalls   = 0;
    for (int i = 0; i < ROW_W; i++) begin
      c = earliest;
      while (!vhist[c[15:0]] && c < earliest + 1000) begin
        c++;
        stalls++;
      end
      exp_acc.push_back(c);
      exp_wen.push_back(c + 1);
      exp_d.push_back(dhist[c[15:0]]);
      earliest = c + SLOT;
    end
    exp_wen.push_back(exp_acc[ROW_W-1] + SLOT + 1);
    exp_d.push_back(32'h0);
    exp_wen.push_back(exp_acc[ROW_W-1] + 2 * SLOT + 1);
    exp_d.push_back(32'h0);

    vectors++;
    if (acc_q.size() != ROW_W) begin
      errors++;
      $display("FAIL %s acc_count: got %0d, required %0d", tag, acc_q.size(), ROW_W);
    end
    for (int i = 0; i < ROW_W && i < acc_q.size(); i++) begin
      vectors++;
      if (acc_q[i] != exp_acc[i]) begin
        errors++;
        $display("FAIL %s accept[%0d]: cycle %0d, required %0d", tag, i, acc_q[i] - sc, exp_acc[i] - sc);
      end
    end
    vectors++;
    if (wen_q.size() != ROW_W + 2) begin
      errors++;
      $display("FAIL %s wen_count: got %0d, required %0d", tag, wen_q.size(), ROW_W + 2);
    end
    for (int i = 0; i < ROW_W + 2 && i < wen_q.size(); i++) begin
      vectors++;
      if (wen_q[i] != exp_wen[i] || wd_q[i] !== exp_d[i]) begin
        errors++;
        $display("FAIL %s wen[%0d]: cycle %0d data %h, required cycle %0d data %h",
                 tag, i, wen_q[i] - sc, wd_q[i], exp_wen[i] - sc, exp_d[i]);
      end
    end
    nres = ROW_W - DISP + 1;
    vectors++;
    if (res_cyc_q.size() != nres) begin
      errors++;
      $display("FAIL %s res_count: got %0d, required %0d", tag, res_cyc_q.size(), nres);
    end
    for (int k = 0; k < nres && k < res_cyc_q.size(); k++) begin
      vectors++;
      if (res_col_q[k] != DISP - 1 + k || res_cyc_q[k] != exp_wen[DISP + 1 + k] + 1) begin
        errors++;
        $display("FAIL %s res[%0d]: col %0d cycle %0d, required col %0d cycle %0d", tag, k,
                 res_col_q[k], res_cyc_q[k] - sc, DISP - 1 + k, exp_wen[DISP + 1 + k] + 1 - sc);
      end
    end
    if (done_q.size() == 1) begin
      vectors++;
      if (done_q[0] != exp_wen[ROW_W + 1] + 1) begin
        errors++;
        $display("FAIL %s row_done: cycle %0d, required %0d", tag, done_q[0] - sc, exp_wen[ROW_W + 1] + 1 - sc);
      end
      vectors++;
      if (busy_cnt != done_q[0] - sc) begin
        errors++;
        $display("FAIL %s busy_cycles: got %0d, required %0d", tag, busy_cnt, done_q[0] - sc);
      end
    end
    vectors++;
    if (ready_cnt != ROW_W + stalls) begin
      errors++;
      $display("FAIL %s ready_cycles: got %0d, required %0d", tag, ready_cnt, ROW_W + stalls);
    end
`ifdef CORR_SCAN_STALL_CNT_EN
    exp_stall = stalls;
`else
    exp_stall = 0;
`endif
    vectors++;
    if (int'(bus.stall_cnt) != exp_stall) begin
      errors++;
      $display("FAIL %s stall_cnt: got %0d, required %0d", tag, bus.stall_cnt, exp_stall);
    end
    $display("row %s: %0d accepts, %0d results, %0d stall cycles", tag, acc_q.size(), res_cyc_q.size(), stalls);
  endtask

  task automatic test_reset;
    bus.start = 1'b1;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    vectors++;
    if (bus.wen !== 1'b0 || bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.res_valid !== 1'b0 ||
        bus.res_col !== '0 || bus.row_done !== 1'b0 || bus.stall_cnt !== 16'h0 ||
        {bus.d_l_1, bus.d_l_2, bus.d_r_1, bus.d_r_2} !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: wen=%b rdy=%b busy=%b rv=%b col=%0d done=%b stall=%0d, required all 0",
               bus.wen, bus.in_ready, bus.busy, bus.res_valid, bus.res_col, bus.row_done, bus.stall_cnt);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk); #1;
    vectors++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_over_start: busy=%b, required 0", bus.busy);
    end
    $display("reset: outputs checked under rst");
  endtask

  task automatic test_full_rate;
    int sc;
    run_row(0, 1'b0, -1, 0, sc);
    check_row(sc, "full_rate");
  endtask

  task automatic test_random_starve;
    int sc;
    run_row(35, 1'b1, -1, 0, sc);
    check_row(sc, "random_starve_mid_start");
  endtask

  task automatic test_starvation;
    int sc;
    run_row(0, 1'b0, 10, 0, sc);
    check_row(sc, "gap7");
  endtask

  task automatic test_back_to_back;
    int sc1, sc2, done1;
    run_row(10, 1'b0, -1, 0, sc1);
    check_row(sc1, "b2b_first");
    done1 = (done_q.size() > 0) ? done_q[0] : -100;
    run_row(10, 1'b0, -1, 0, sc2);
    check_row(sc2, "b2b_second");
    vectors++;
    if (sc2 != done1 + 1) begin
      errors++;
      $display("FAIL b2b_start_cycle: start at %0d, required %0d", sc2, done1 + 1);
    end
  endtask

  task automatic test_reset_mid_row;
    int sc;
    run_row(0, 1'b0, -1, 31, sc);
    run_row(20, 1'b0, -1, 0, sc);
    check_row(sc, "after_reset");
  endtask

  task automatic test_short_row;
    int nwen, nres, ndone, last_wen, done_c, bad_gap;
    nwen = 0; nres = 0; ndone = 0; last_wen = -1; done_c = -1; bad_gap = 0;
    sbus.in_valid = 1'b1;
    {sbus.in_l_1, sbus.in_l_2, sbus.in_r_1, sbus.in_r_2} = $urandom;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      sbus.start = (i == 0) || (i == 5);
      @(negedge clk); #1;
      if (sbus.wen) begin
        if (last_wen >= 0 && cyc - last_wen != S_SLOT) bad_gap++;
        last_wen = cyc;
        nwen++;
      end
      if (sbus.res_valid) nres++;
      if (sbus.row_done) begin
        ndone++;
        done_c = cyc;
      end
    end
    sbus.start = 1'b0;
    sbus.in_valid = 1'b0;
    vectors++;
    if (nwen != S_ROW_W + 2) begin
      errors++;
      $display("FAIL short_wen_count: got %0d, required %0d", nwen, S_ROW_W + 2);
    end
    vectors++;
    if (nres != 0) begin
      errors++;
      $display("FAIL short_res_valid: got %0d, required 0", nres);
    end
    vectors++;
    if (ndone != 1) begin
      errors++;
      $display("FAIL short_row_done_count: got %0d, required 1", ndone);
    end
    vectors++;
    if (done_c != last_wen + 1) begin
      errors++;
      $display("FAIL short_row_done_cycle: got %0d, required %0d", done_c, last_wen + 1);
    end
    vectors++;
    if (bad_gap != 0) begin
      errors++;
      $display("FAIL short_wen_spacing: %0d gaps not %0d cycles, required 0", bad_gap, S_SLOT);
    end
    $display("short row: %0d wen, %0d results, %0d row_done", nwen, nres, ndone);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    {bus.in_l_1, bus.in_l_2, bus.in_r_1, bus.in_r_2} = 32'h0;
    sbus.start = 1'b0;
    sbus.in_valid = 1'b0;
    {sbus.in_l_1, sbus.in_l_2, sbus.in_r_1, sbus.in_r_2} = 32'h0;
    test_reset;
    test_full_rate;
    test_random_starve;
    test_starvation;
    test_back_to_back;
    test_reset_mid_row;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    test_short_row;
    vectors++;
    if (bus.busy !== 1'b0 || bus.wen !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_rows: busy=%b wen=%b, required 0 0", bus.busy, bus.wen);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
